// File: rtl/datapath_pkg.sv
// Shared datapath constants: default word width and named mux select encodings.
package datapath_pkg;

  localparam int XLEN = 32;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : datapath_pkg

// File: rtl/mux2_sel32.sv
// Two-input word mux with a zero-latency combinational output and a
// registered copy plus valid flag for pipelined consumers.
module mux2_sel32
  import datapath_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_valid
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_y_valid;

  // Plain ternary so an unknown select propagates X in simulation
  // rather than being decoded to one side.
  assign w_y = (sel == SEL_B) ? b : a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q     <= RESET_VAL;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= in_valid;
      if (in_valid) begin
        r_y_q <= w_y;
      end
    end
  end

  assign y       = w_y;
  assign y_q     = r_y_q;
  assign y_valid = r_y_valid;

endmodule : mux2_sel32

// File: tb/tb_mux2_sel32.sv
// Directed-vector bench for mux2_sel32: combinational select, capture, hold,
// reset priority, full-width pass-through and back-to-back streaming.
module tb_mux2_sel32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic        in_valid;
  logic [31:0] y;
  logic [31:0] y_q;
  logic        y_valid;

  int n_total = 0;
  int n_bad   = 0;

  mux2_sel32 #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .in_valid (in_valid),
    .y        (y),
    .y_q      (y_q),
    .y_valid  (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_a   [4] = '{32'd1, 32'd3, 32'd5, 32'd7};
  logic [31:0] stream_b   [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
  logic        stream_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] stream_exp [4] = '{32'd1, 32'd4, 32'd5, 32'd8};

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = 1'b0;

    // combinational select, no clock edge in between
    a = 32'd50; b = 32'd100; sel = 1'b0; #1; chk("comb_a50", y, 32'd50);
    sel = 1'b1; #1;                          chk("comb_b100", y, 32'd100);
    a = 32'd90; b = 32'd800; sel = 1'b0; #1; chk("comb_a90", y, 32'd90);
    sel = 1'b1; #1;                          chk("comb_b800", y, 32'd800);

    step(); step();
    chk("rst_yq", y_q, 32'd0);
    chk("rst_valid", {31'd0, y_valid}, 32'd0);

    rst = 1'b0; a = 32'd50; b = 32'd100; sel = 1'b1; in_valid = 1'b1;
    step();
    chk("cap_yq100", y_q, 32'd100);
    chk("cap_valid1", {31'd0, y_valid}, 32'd1);
    sel = 1'b0;
    step();
    chk("cap_yq50", y_q, 32'd50);

    a = 32'd90; b = 32'd800; sel = 1'b1;
    step();
    chk("cap_yq800", y_q, 32'd800);

    // hold: in_valid low, inputs keep changing
    in_valid = 1'b0; a = 32'd1; b = 32'd2; sel = 1'b0; #1;
    chk("hold_comb_a", y, 32'd1);
    step();
    chk("hold_yq", y_q, 32'd800);
    chk("hold_valid0", {31'd0, y_valid}, 32'd0);
    sel = 1'b1; #1;
    chk("hold_comb_b", y, 32'd2);
    step();
    chk("hold_yq2", y_q, 32'd800);
    chk("hold_valid0b", {31'd0, y_valid}, 32'd0);

    // reset wins over in_valid
    rst = 1'b1; in_valid = 1'b1; a = 32'd90; sel = 1'b0;
    step();
    chk("prio_yq", y_q, 32'd0);
    chk("prio_valid", {31'd0, y_valid}, 32'd0);
    chk("prio_comb", y, 32'd90);
    rst = 1'b0; in_valid = 1'b0;

    // full-width pass-through
    a = 32'hFFFF_FFFF; b = 32'h8000_0001; sel = 1'b0; #1;
    chk("wide_comb_a", y, 32'hFFFF_FFFF);
    sel = 1'b1; #1;
    chk("wide_comb_b", y, 32'h8000_0001);
    in_valid = 1'b1;
    step();
    chk("wide_yq_b", y_q, 32'h8000_0001);
    sel = 1'b0;
    step();
    chk("wide_yq_a", y_q, 32'hFFFF_FFFF);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      a = stream_a[i]; b = stream_b[i]; sel = stream_sel[i];
      step();
      chk($sformatf("stream_yq%0d", i), y_q, stream_exp[i]);
      chk($sformatf("stream_valid%0d", i), {31'd0, y_valid}, 32'd1);
    end

    // reset mid-stream; combinational output keeps tracking
    rst = 1'b1; a = 32'd3; b = 32'd4; sel = 1'b1;
    step();
    chk("mid_rst_yq", y_q, 32'd0);
    chk("mid_rst_valid", {31'd0, y_valid}, 32'd0);
    chk("mid_rst_comb", y, 32'd4);
    rst = 1'b0;
    step();
    chk("post_rst_yq", y_q, 32'd4);
    chk("post_rst_valid", {31'd0, y_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_mux2_sel32

// File: doc/mux2_sel32.md
Name: mux2_sel32

Overview:
Two-input word multiplexer used in the RISC-V datapath, e.g. ALU operand B select and PC-next select.
- Provides a zero-latency combinational result for in-cycle datapath use.
- Provides a registered copy with a valid flag for pipelined consumers.
- Single clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 32, data width of both inputs and both outputs.
- RESET_VAL, 0, value loaded into the registered output on reset.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  data input 0.
- b  input  WIDTH  data input 1.
- sel  input  1  select: 0 chooses a, 1 chooses b.
- in_valid  input  1  qualifies a/b/sel for capture into the register.
- y  output  WIDTH  combinational result.
- y_q  output  WIDTH  registered result.
- y_valid  output  1  registered valid flag for y_q.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- y = (sel == 1) ? b : a, purely combinational.
  - Zero latency.
  - Not affected by clk, rst or in_valid.
  - Follows a, b and sel within the same delta.
- Synthesis: a sel value of X/Z must not be decoded specially. In simulation, y may propagate X.
- Registered path updates on the rising edge of clk, with priority rst > in_valid:
  - rst = 1: y_q <= RESET_VAL, y_valid <= 0. This overrides in_valid in the same cycle.
  - rst = 0, in_valid = 1: y_q <= current y, y_valid <= 1.
  - rst = 0, in_valid = 0: y_q holds its previous value, y_valid <= 0.
- Registered-path latency: exactly 1 cycle from in_valid sampled high to y_valid high with the matching y_q.
- No backpressure; a new word is accepted on every cycle in which in_valid = 1.
- Reset asserted mid-stream: y_valid drops the next edge and y_q is cleared. The combinational y keeps tracking the inputs throughout.
- Width rules:
  - No sign extension, truncation or arithmetic.
  - Bits pass through unchanged, bit-for-bit.
  - All WIDTH >= 1 are legal.
- No internal state other than y_q and y_valid; no state machine.
- Power-up before the first reset: y_q and y_valid are undefined. Consumers must reset before use.

Decomposition:
- Shared package (datapath_pkg): XLEN = 32 as the default for WIDTH, plus localparams SEL_A = 1'b0 and SEL_B = 1'b1 so select encodings are named at all call sites.
- No sub-module. The combinational mux and the output register are one block; a separate flop wrapper adds nothing.

Test Plan:
- Static select, both ways: a=50, b=100; sel=0 -> y=50; sel=1 -> y=100, both with no clock edge required. Then a=90, b=800; sel=0 -> y=90; sel=1 -> y=800.
- Registered capture:
  - rst=1 for 2 cycles -> y_q=0, y_valid=0.
  - Release rst; a=50, b=100, sel=1, in_valid=1 -> the next edge gives y_q=100, y_valid=1.
  - Then sel=0 -> the next edge gives y_q=50.
- Hold: after capturing y_q=800, set in_valid=0 and change a=1, b=2, sel toggling -> y_q stays 800, y_valid=0, and y follows the inputs combinationally.
- Reset priority: rst=1 and in_valid=1 in the same cycle with a=90, sel=0 -> after the edge y_q=0 (RESET_VAL), y_valid=0.
- Width/pass-through: a=32'hFFFF_FFFF, b=32'h8000_0001; sel=0 -> y=FFFF_FFFF; sel=1 -> y=8000_0001. Captured y_q matches bit-for-bit.
- Back-to-back stream: in_valid=1 for 4 cycles with sel=0,1,0,1 and (a,b) = (1,2), (3,4), (5,6), (7,8) -> y_q sequence is 1, 4, 5, 8 on consecutive edges, y_valid held at 1.
